// File: rtl/bru_pkg.sv
// Shared constants, FSM encoding and resolution outcome codes for the branch
// resolve unit.
package bru_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CORRECT,
    MISPRED_TGT,
    MISPRED_DIR,
    MISPRED_ALIAS
  } outcome_e;

  // A taken branch mispredicts on a miss or a wrong target, a not-taken branch
  // on any hit, and a non-branch whenever the BTB aliased onto it.
  function automatic outcome_e classify(input logic is_branch, input logic taken,
                                        input logic hit, input logic tgt_match);
    if (!is_branch) return hit ? MISPRED_ALIAS : CORRECT;
    if (taken)      return (hit && tgt_match) ? CORRECT : MISPRED_TGT;
    return hit ? MISPRED_DIR : CORRECT;
  endfunction

endpackage

// File: rtl/bru_pred_queue.sv
// Shift register carrying fetch-time BTB predictions from IF down to EXE.
// Holds on stall; clear wipes every entry, including the load of that cycle.
module bru_pred_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         stall,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_pc,
  input  logic         in_hit,
  input  logic [W-1:0] in_tgt,
  output logic         head_valid,
  output logic [W-1:0] head_pc,
  output logic         head_hit,
  output logic [W-1:0] head_tgt
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     pc_q  [DEPTH];
  logic             hit_q [DEPTH];
  logic [W-1:0]     tgt_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every entry
  // samples its neighbour's pre-edge value and the shift cannot ripple.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: the payload has no reset; it is only ever looked at behind its
  // valid bit, which is reset above.
  always_ff @(posedge clk) begin
    if (!stall) begin
      pc_q[0]  <= in_pc;
      hit_q[0] <= in_hit;
      tgt_q[0] <= in_tgt;
      for (int i = 1; i < DEPTH; i++) begin
        pc_q[i]  <= pc_q[i-1];
        hit_q[i] <= hit_q[i-1];
        tgt_q[i] <= tgt_q[i-1];
      end
    end
  end

  assign head_valid = valid_q[DEPTH-1];
  assign head_pc    = pc_q[DEPTH-1];
  assign head_hit   = hit_q[DEPTH-1];
  assign head_tgt   = tgt_q[DEPTH-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EXE-stage branch resolution: checks BTB predictions, raises flush/redirect
// and BTB update requests. Define BRU_PERF_CNT_EN to build the perf counters.
module branch_resolve_unit #(
  parameter int PIPE_DEPTH = 2,
  parameter int XLEN       = bru_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic            btb_hit,
  input  logic [XLEN-1:0] btb_addr,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            btb_wr_en,
  output logic [XLEN-1:0] btb_wr_pc,
  output logic [XLEN-1:0] btb_wr_imm,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  bru_pkg::state_e   state_q;
  bru_pkg::outcome_e outcome;

  logic            head_valid, head_hit;
  logic [XLEN-1:0] head_pc, head_tgt;
  logic            resolve, hit_used, mispred, update;
  logic [XLEN-1:0] tgt_taken, tgt_fall, redirect_d;
  logic            flush_q, wr_en_q;
  logic [XLEN-1:0] redirect_q, wr_pc_q, wr_imm_q;

  bru_pred_queue #(.DEPTH(PIPE_DEPTH), .W(XLEN)) u_queue (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .clear      (state_q == bru_pkg::FLUSH),
    .in_valid   (if_valid),
    .in_pc      (if_pc),
    .in_hit     (btb_hit),
    .in_tgt     (btb_addr),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_hit   (head_hit),
    .head_tgt   (head_tgt)
  );

  // A stale head belonging to a different instruction counts as a miss.
  always_comb begin
    resolve    = (state_q == bru_pkg::NORMAL) && !stall && ex_valid;
    hit_used   = head_valid && (head_pc == ex_pc) && head_hit;
    tgt_taken  = ex_pc + ex_imm;
    tgt_fall   = ex_pc + XLEN'(bru_pkg::INSTR_BYTES);
    outcome    = bru_pkg::classify(ex_is_branch, ex_taken, hit_used, head_tgt == tgt_taken);
    mispred    = resolve && (outcome != bru_pkg::CORRECT);
    update     = resolve && ex_is_branch && ex_taken && !hit_used;
    redirect_d = (outcome == bru_pkg::MISPRED_TGT) ? tgt_taken : tgt_fall;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= bru_pkg::NORMAL;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      wr_en_q    <= 1'b0;
      wr_pc_q    <= '0;
      wr_imm_q   <= '0;
    end else begin
      flush_q <= 1'b0;
      wr_en_q <= 1'b0;
      if (state_q == bru_pkg::FLUSH) begin
        state_q <= bru_pkg::NORMAL;
      end else begin
        if (mispred) begin
          state_q    <= bru_pkg::FLUSH;
          flush_q    <= 1'b1;
          redirect_q <= redirect_d;
        end
        if (update) begin
          wr_en_q  <= 1'b1;
          wr_pc_q  <= ex_pc;
          wr_imm_q <= ex_imm;
        end
      end
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign btb_wr_en   = wr_en_q;
  assign btb_wr_pc   = wr_pc_q;
  assign btb_wr_imm  = wr_imm_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve && ex_is_branch && (branch_cnt_q != '1))
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispred && (mispred_cnt_q != '1))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EXE-stage consumer of BTB predictions in the 4-stage pipeline.
- Carries each fetch-time prediction (hit, target) down to EXE and compares it with the actual branch outcome.
- On mismatch: issues a one-cycle flush with the corrected PC.
- Produces the BTB write request (enable, branch PC, immediate) that feeds the BTB's update port.

Parameters:
- PIPE_DEPTH, 2, pipeline registers between IF and EXE; depth of the prediction queue.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- if_valid  in  1  valid instruction fetched this cycle
- if_pc  in  XLEN  PC of fetched instruction
- btb_hit  in  1  BTB hit for if_pc
- btb_addr  in  XLEN  BTB predicted target for if_pc
- stall  in  1  pipeline freeze; queue and resolution hold
- ex_valid  in  1  instruction in EXE is valid
- ex_is_branch  in  1  EXE instruction is a conditional branch or jump
- ex_taken  in  1  actual branch outcome
- ex_pc  in  XLEN  PC of EXE instruction
- ex_imm  in  XLEN  branch immediate
- flush  out  1  kill IF/ID contents and redirect fetch
- redirect_pc  out  XLEN  corrected fetch PC, valid while flush=1
- btb_wr_en  out  1  BTB update strobe
- btb_wr_pc  out  XLEN  branch PC to install
- btb_wr_imm  out  XLEN  immediate to install (BTB forms target = pc+imm)
- branch_cnt  out  32  resolved branches (see Optional Feature)
- mispred_cnt  out  32  mispredictions (see Optional Feature)

Behaviour:
- Reset: all queue entries invalid; FSM=NORMAL; flush=0, redirect_pc=0, btb_wr_en=0, btb_wr_pc=0, btb_wr_imm=0, counters=0. Reset mid-operation discards pending flush and update.
- Queue: PIPE_DEPTH-entry shift register of {valid, pc, hit, target}. Shifts when stall=0; the tail loads {if_valid, if_pc, btb_hit, btb_addr}.
- Head prediction is used only if head.valid=1 and head.pc==ex_pc; otherwise it is treated as hit=0.
- Resolution happens when FSM=NORMAL, stall=0, ex_valid=1. Let T = ex_pc+ex_imm and F = ex_pc+4, both mod 2^XLEN (wrap-around allowed).
  - branch, taken, hit, target==T: correct; no action.
  - branch, taken, hit, target!=T: mispredict; redirect T.
  - branch, taken, no hit: mispredict; redirect T; BTB update.
  - branch, not taken, hit: mispredict; redirect F.
  - branch, not taken, no hit: correct; no action.
  - non-branch with hit (alias): mispredict; redirect F; not counted as a branch.
- Outputs are registered with 1-cycle latency after resolution. flush and btb_wr_en are one-cycle pulses.
  - BTB update: btb_wr_pc=ex_pc, btb_wr_imm=ex_imm.
  - When both a mispredict and a BTB update occur, they pulse in the same cycle.
- FSM:
  - NORMAL -> FLUSH on mispredict.
  - FLUSH lasts exactly one cycle (flush=1), then returns to NORMAL.
  - In FLUSH: all queue entries are invalidated, including the tail load that cycle; EXE inputs are ignored (wrong-path).
- Flush overrides stall: FLUSH completes even if stall=1.
- A resolution pending under stall is deferred, not lost, and is evaluated on the first cycle stall=0.
- redirect_pc holds its last value when flush=0.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - branch_cnt increments per resolved branch (ex_is_branch=1).
  - mispred_cnt increments per mispredict, including aliases.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: counters are not instantiated; the ports remain present, tied to 0.

Decomposition:
- Package bru_pkg:
  - XLEN
  - INSTR_BYTES=4
  - FSM state encoding (NORMAL, FLUSH)
  - resolution outcome codes (CORRECT, MISPRED_TGT, MISPRED_DIR, MISPRED_ALIAS)
- Sub-module bru_pred_queue: parameterised shift register with stall hold and flush invalidate.

Test Plan:
- Cold miss: if_pc=0x100, btb_hit=0; two cycles later EXE ex_pc=0x100, branch, taken, imm=0x40 -> next cycle flush=1, redirect_pc=0x140, btb_wr_en=1, btb_wr_pc=0x100, btb_wr_imm=0x40.
- Correct hit: btb_hit=1, btb_addr=0x140; resolve taken, imm=0x40 -> flush=0, btb_wr_en=0 throughout; branch_cnt=1, mispred_cnt=0 (macro on).
- Direction mispredict: hit, target=0x140; resolve not taken at ex_pc=0x100 -> flush one cycle, redirect_pc=0x104; next EXE input ignored; queue entries all invalid.
- Wrap-around: ex_pc=0xFFFFFFF0, imm=0x20, taken, no hit -> redirect_pc=0x00000010; ex_pc=0xFFFFFFFC not taken with hit -> redirect_pc=0x00000000.
- Stall: mispredicting branch in EXE with stall=1 for 3 cycles -> no flush during stall; flush one cycle after stall drops; queue contents unchanged while stalled.
- Reset mid-FLUSH: rstn low in the flush cycle -> flush=0, btb_wr_en=0, counters=0, queue invalid immediately (asynchronous).
